// File: rtl/uart_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CHECK,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_CHECKSUM = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_FRAME    = 2'd3;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int unsigned CLKS_PER_BIT = 868;

   // True while a frame is being received and the inter-byte timer must run.
   function automatic logic in_frame(state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
   endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// Receiver byte stream in, imem write port out.
interface uart_boot_loader_if #(
   parameter int unsigned ADDR_W = 12
);
   logic              rx_valid;
   logic [7:0]        rx_byte;
   logic              rx_err;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;

   modport master (output rx_valid, rx_byte, rx_err,
                   input  mem_we, mem_addr, mem_data);
   modport slave  (input  rx_valid, rx_byte, rx_err,
                   output mem_we, mem_addr, mem_data);
endinterface

// File: rtl/uart_byte_timeout.sv
// Reloadable down-counter; expire_c flags TIMEOUT-1 idle cycles while enabled.
module uart_byte_timeout #(
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic reload,
   input  logic enable,
   output logic expire_c
);
   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (reload) begin
         cnt <= LOAD;
      end else if (enable && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // A byte in the expiry cycle wins over the timeout.
   assign expire_c = enable && !reload && (cnt == '0);

endmodule

// File: rtl/uart_boot_loader.sv
// Frame parser: assembles serial bytes into imem words, holds the CPU in reset while loading.
module uart_boot_loader
   import uart_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned BASE_ADDR = 0,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT   = 100000
) (
   input  logic                clk,
   input  logic                reset,
   uart_boot_loader_if.slave   bus,
   output logic                cpu_reset,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [1:0]          err_code
);
   localparam int unsigned IDX_W = ADDR_W + 1;
   localparam logic [16:0] MAX_LEN = 17'(1 << ADDR_W);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   state_t           state;
   logic [15:0]      len;
   logic [IDX_W-1:0] idx;
   logic [23:0]      shreg;
   logic [1:0]       bcnt;
   logic [7:0]       chk;

   logic [15:0] len_full_c;
   logic        last_word_c;
   logic        expire_c;
   logic        frame_c;

   assign len_full_c  = {bus.rx_byte, len[7:0]};
   assign last_word_c = ((17'(idx) + 17'd1) == {1'b0, len});
   assign frame_c     = in_frame(state);

   uart_byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .reload   (bus.rx_valid),
      .enable   (frame_c),
      .expire_c (expire_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         len          <= '0;
         idx          <= '0;
         shreg        <= '0;
         bcnt         <= '0;
         chk          <= '0;
         bus.mem_we   <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_data <= '0;
         cpu_reset    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_code     <= ERR_NONE;
      end else begin
         bus.mem_we <= 1'b0;
         if (!frame_c) begin
            // Waiting for a frame start; everything else is noise.
            if (bus.rx_valid && (bus.rx_byte == SYNC_BYTE)) begin
               state     <= LEN_LO;
               busy      <= 1'b1;
               cpu_reset <= 1'b1;
               done      <= 1'b0;
               error     <= 1'b0;
               err_code  <= ERR_NONE;
               chk       <= '0;
               idx       <= '0;
               bcnt      <= '0;
            end
         end else if (bus.rx_valid && bus.rx_err) begin
            state    <= ERR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_FRAME;
         end else if (bus.rx_valid) begin
            case (state)
               LEN_LO: begin
                  len[7:0] <= bus.rx_byte;
                  state    <= LEN_HI;
               end
               LEN_HI: begin
                  len[15:8] <= bus.rx_byte;
                  if (len_full_c == 16'd0) begin
                     state <= CHECK;
                  end else if ({1'b0, len_full_c} > MAX_LEN) begin
                     state    <= ERR;
                     busy     <= 1'b0;
                     error    <= 1'b1;
                     err_code <= ERR_FRAME;
                  end else begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  chk   <= chk ^ bus.rx_byte;
                  bcnt  <= bcnt + 2'd1;
                  shreg <= {bus.rx_byte, shreg[23:8]};
                  if (bcnt == 2'd3) begin
                     bus.mem_we   <= 1'b1;
                     bus.mem_addr <= BASE + idx[ADDR_W-1:0];
                     bus.mem_data <= {bus.rx_byte, shreg};
                     idx          <= idx + IDX_W'(1);
                     if (last_word_c) state <= CHECK;
                  end
               end
               CHECK: begin
                  if (bus.rx_byte == chk) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     cpu_reset <= 1'b0;
                  end else begin
                     state    <= ERR;
                     busy     <= 1'b0;
                     error    <= 1'b1;
                     err_code <= ERR_CHECKSUM;
                  end
               end
               default: ;
            endcase
         end else if (expire_c) begin
            state    <= ERR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_TIMEOUT;
         end
      end
   end

endmodule
